// File: rtl/scratchpad_ram.sv
// Scratchpad RAM: 2^THREADBITS per-thread regions in one block RAM.
// Writes go through a one-cycle staging register. Reads take one cycle and
// forward from a same-cycle write first, then from the staged write, then
// from the array. A clear request zeroes the whole array one word per cycle.
module scratchpad_ram #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDRBITS   = 10,
    parameter int THREADBITS = 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  clear_i,
    input  logic                  wr_en_i,
    input  logic [THREADBITS-1:0] wr_thread_i,
    input  logic [ADDRBITS-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [THREADBITS-1:0] rd_thread_i,
    input  logic [ADDRBITS-1:0]   rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  busy_o
);

    localparam int FABITS = THREADBITS + ADDRBITS;
    localparam int DEPTH  = 1 << FABITS;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t              state_q, state_d;
    logic [FABITS-1:0]   clr_cnt_q, clr_cnt_d;
    logic                clr_last;

    logic                idle;
    logic                wr_acc, rd_acc;
    logic [FABITS-1:0]   wr_fa, rd_fa;

    logic                stg_vld_q;
    logic [FABITS-1:0]   stg_addr_q;
    logic [DATA_WIDTH-1:0] stg_data_q;

    logic                mem_we;
    logic [FABITS-1:0]   mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_rd_q;

    logic                fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                fwd_vld_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;
    logic                rd_valid_q;
    logic [DATA_WIDTH-1:0] hold_q;

    // Requests are only honoured when idle; a clear in the same cycle drops them.
    assign idle     = (state_q == S_IDLE);
    assign wr_acc   = idle && wr_en_i && !clear_i;
    assign rd_acc   = idle && rd_en_i && !clear_i;
    assign wr_fa    = {wr_thread_i, wr_addr_i};
    assign rd_fa    = {rd_thread_i, rd_addr_i};
    assign clr_last = &clr_cnt_q;

    // FSM state register; reset forces IDLE.
    always_ff @(posedge clock_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // FSM next state: clear starts a single pass, exits after the all-ones address.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (clear_i)  state_d = S_CLEAR;
            S_CLEAR: if (clr_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy flag and next clear address.
    always_comb begin
        busy_o    = (state_q == S_CLEAR);
        clr_cnt_d = busy_o ? clr_cnt_q + 1'b1 : '0;
    end

    // Clear counter; wraps to 0 exactly as the FSM leaves CLEAR.
    always_ff @(posedge clock_i) begin
        if (reset_i) clr_cnt_q <= '0;
        else         clr_cnt_q <= clr_cnt_d;
    end

    // Staging valid bit; a pending write is dropped by reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) stg_vld_q <= 1'b0;
        else         stg_vld_q <= wr_acc;
    end

    // Staging address/data captured on an accepted write.
    always_ff @(posedge clock_i) begin
        if (wr_acc) begin
            stg_addr_q <= wr_fa;
            stg_data_q <= wr_data_i;
        end
    end

    // Single array write port: clear pass and staged commit never overlap,
    // since nothing is staged during the first CLEAR cycle.
    always_comb begin
        mem_we = !reset_i && (busy_o || stg_vld_q);
        mem_wa = busy_o ? clr_cnt_q : stg_addr_q;
        mem_wd = busy_o ? '0 : stg_data_q;
    end

    // Block RAM: synchronous write and registered read, no reset on contents.
    always_ff @(posedge clock_i) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
        if (rd_acc) ram_rd_q <= mem[rd_fa];
    end

    // Forwarding priority: same-cycle write, then staged write.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = stg_data_q;
        if (wr_acc && (wr_fa == rd_fa)) begin
            fwd_hit  = 1'b1;
            fwd_data = wr_data_i;
        end else if (stg_vld_q && (stg_addr_q == rd_fa)) begin
            fwd_hit = 1'b1;
        end
    end

    // Forwarded data captured alongside the RAM read.
    always_ff @(posedge clock_i) begin
        if (rd_acc) fwd_data_q <= fwd_data;
    end

    // Read valid, forward select and held output value.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_valid_q <= 1'b0;
            fwd_vld_q  <= 1'b0;
            hold_q     <= '0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) fwd_vld_q <= fwd_hit;
            if (rd_valid_q) hold_q <= rd_data_o;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_valid_q ? (fwd_vld_q ? fwd_data_q : ram_rd_q) : hold_q;

endmodule

// File: tb/tb_scratchpad_ram.sv
// Directed bench for scratchpad_ram with a word-level reference model.
module tb_scratchpad_ram;

    localparam int DW      = 256;
    localparam int AB      = 10;
    localparam int TB      = 1;
    localparam int CLR_LEN = 1 << (AB + TB);

    logic          clk = 0;
    logic          reset, clear, wr_en, rd_en;
    logic [TB-1:0] wr_thread, rd_thread;
    logic [AB-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data, rd_data;
    logic          rd_valid, busy;

    int n_tests = 0;
    int n_fail  = 0;

    scratchpad_ram #(.DATA_WIDTH(DW), .ADDRBITS(AB), .THREADBITS(TB)) dut (
        .clock_i(clk), .reset_i(reset), .clear_i(clear),
        .wr_en_i(wr_en), .wr_thread_i(wr_thread), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_thread_i(rd_thread), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    // Reference model: writes land in the word array immediately (write-first),
    // a clear pass zeroes word k in the k-th busy cycle.
    logic [DW-1:0] m_mem [CLR_LEN];
    bit            m_known [CLR_LEN];
    int            m_left = 0;
    int            m_idx;
    bit            m_started = 0;
    bit            e_valid = 0;
    bit            e_known = 0;
    logic [DW-1:0] e_data = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0; e_valid = 0; e_data = '0; e_known = 1; m_started = 1;
        end else if (m_left > 0) begin
            m_idx = CLR_LEN - m_left;
            m_mem[m_idx] = '0; m_known[m_idx] = 1;
            m_left--; e_valid = 0;
        end else if (clear) begin
            m_left = CLR_LEN; e_valid = 0;
        end else begin
            if (wr_en) begin
                m_mem[{wr_thread, wr_addr}]   = wr_data;
                m_known[{wr_thread, wr_addr}] = 1;
            end
            if (rd_en) begin
                e_valid = 1;
                e_data  = m_mem[{rd_thread, rd_addr}];
                e_known = m_known[{rd_thread, rd_addr}];
            end else begin
                e_valid = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_started) begin
            chk("model_busy", {255'b0, busy}, {255'b0, m_left > 0});
            chk("model_rd_valid", {255'b0, rd_valid}, {255'b0, e_valid});
            if (e_known) chk("model_rd_data", rd_data, e_data);
        end
    end

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        clear = 0; wr_en = 0; rd_en = 0; reset = 0;
    endtask

    task automatic do_wr(input int th, input int a, input logic [DW-1:0] d);
        wr_en = 1; wr_thread = TB'(th); wr_addr = AB'(a); wr_data = d;
    endtask

    task automatic do_rd(input int th, input int a);
        rd_en = 1; rd_thread = TB'(th); rd_addr = AB'(a);
    endtask

    // Read one word and compare against a literal.
    task automatic rd_lit(input string nm, input int th, input int a, input logic [DW-1:0] exp);
        idle_in(); do_rd(th, a); cycle(); idle_in();
        chk({nm, "_valid"}, {255'b0, rd_valid}, {255'b0, 1'b1});
        chk(nm, rd_data, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        idle_in();
        wr_thread = '0; wr_addr = '0; wr_data = '0; rd_thread = '0; rd_addr = '0;
        reset = 1;
        cycle(); cycle();
        chk("reset_busy", {255'b0, busy}, '0);
        chk("reset_rd_valid", {255'b0, rd_valid}, '0);
        chk("reset_rd_data", rd_data, '0);
        idle_in();
        cycle();

        // Write then read three cycles later.
        do_wr(0, 'h005, {32{8'hA5}}); cycle(); idle_in();
        cycle(); cycle();
        rd_lit("wr_rd_latency", 0, 'h005, {32{8'hA5}});
        cycle();
        chk("hold_valid_low", {255'b0, rd_valid}, '0);
        chk("hold_data", rd_data, {32{8'hA5}});

        // Same-cycle and staged forwarding.
        do_wr(0, 'h010, 256'h1); do_rd(0, 'h010); cycle(); idle_in();
        chk("fwd_same_cycle", rd_data, 256'h1);
        do_rd(0, 'h010); cycle(); idle_in();
        chk("fwd_staged", rd_data, 256'h1);

        // Threads do not alias.
        do_wr(0, 'h3FF, 256'h11); cycle(); idle_in();
        do_wr(1, 'h3FF, 256'h22); cycle(); idle_in();
        rd_lit("thread0_3ff", 0, 'h3FF, 256'h11);
        rd_lit("thread1_3ff", 1, 'h3FF, 256'h22);

        // Reset 100 cycles into a clear pass.
        do_wr(1, 'h200, 256'h77); cycle(); idle_in();
        do_wr(0, 'h000, 256'h55); cycle(); idle_in();
        cycle();
        clear = 1; cycle(); idle_in();
        repeat (100) cycle();
        chk("mid_clear_busy", {255'b0, busy}, {255'b0, 1'b1});
        reset = 1; cycle(); idle_in();
        chk("abort_busy", {255'b0, busy}, '0);
        chk("abort_rd_valid", {255'b0, rd_valid}, '0);
        rd_lit("abort_zeroed", 0, 'h000, '0);
        rd_lit("abort_kept", 1, 'h200, 256'h77);

        // Clear wins over same-cycle write/read; requests ignored while busy.
        do_wr(0, 'h020, 256'h9); cycle(); idle_in();
        clear = 1; do_wr(0, 'h020, 256'h9); do_rd(0, 'h020); cycle(); idle_in();
        chk("clear_drops_rd", {255'b0, rd_valid}, '0);
        n = 0;
        while (busy && n < 3000) begin
            if (n == 1500) begin do_wr(0, 'h005, '1); do_rd(0, 'h005); end
            if (n == 2047) clear = 1;
            cycle(); idle_in();
            n++;
        end
        chk("clear_len", 256'(n), 256'(CLR_LEN));
        cycle();
        chk("no_second_pass", {255'b0, busy}, '0);
        rd_lit("clr_t0_000", 0, 'h000, '0);
        rd_lit("clr_t1_3ff", 1, 'h3FF, '0);
        rd_lit("clr_t0_020", 0, 'h020, '0);
        rd_lit("busy_wr_ignored", 0, 'h005, '0);
        rd_lit("clr_t1_200", 1, 'h200, '0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
